// File: rtl/ysyx_25060170_pkg.sv
// Shared definitions for the ysyx_25060170 fetch path.
//   XLEN              - datapath width
//   RESET_PC_DEFAULT  - default PC after reset (first fetch address)
//   NOP_INST_DEFAULT  - default bubble instruction (addi x0,x0,0)
//   fetch_state_e     - IFU fetch FSM states
//   align_word()      - clears the byte-offset bits of an address
package ysyx_25060170_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        StReqIdle,
        StReq,
        StWait,
        StHold
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~(XLEN'(3));
    endfunction

endpackage

// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch unit. Owns the PC, fetches one word at a time from
// instruction memory and hands (pc, inst) to decode over valid/ready.
//   clk, rst_n          - clock, synchronous active-low reset
//   imem_req_o/addr_o   - fetch request and word-aligned address
//   imem_gnt_i          - request accepted (only looked at in StReq)
//   imem_rvalid_i/rdata - fetch response (only looked at in StWait)
//   inst_valid_o/inst_o/pc_o, inst_ready_i - decode handshake
//   redirect_i/redirect_pc_i - control transfer from writeback
module ysyx_25060170_ifu
    import ysyx_25060170_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            inst_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] inst_q;
    logic [XLEN-1:0] pc_out_q;
    logic            valid_q;
    // Set when the in-flight fetch belongs to a stale PC and must be discarded.
    logic            drop_q;

    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_plus4;

    assign redirect_target = align_word(redirect_pc_i);
    assign pc_plus4        = pc_q + XLEN'(4);

    assign imem_req_o   = (state_q == StReq);
    assign imem_addr_o  = pc_q;
    assign inst_valid_o = valid_q;
    assign inst_o       = inst_q;
    assign pc_o         = pc_out_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StReqIdle;
            pc_q     <= RESET_PC;
            inst_q   <= NOP_INST;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StReqIdle: begin
                    if (redirect_i) pc_q <= redirect_target;
                    state_q <= StReq;
                end
                StReq: begin
                    // An ungranted request may only change address through a redirect.
                    if (redirect_i) pc_q <= redirect_target;
                    if (imem_gnt_i) begin
                        drop_q  <= redirect_i;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (redirect_i) pc_q <= redirect_target;
                    if (imem_rvalid_i) begin
                        drop_q <= 1'b0;
                        if (drop_q || redirect_i) begin
                            state_q <= StReq;
                        end else begin
                            inst_q   <= imem_rdata_i;
                            pc_out_q <= pc_q;
                            valid_q  <= 1'b1;
                            state_q  <= StHold;
                        end
                    end else if (redirect_i) begin
                        drop_q <= 1'b1;
                    end
                end
                StHold: begin
                    // Handshake advances the PC; a redirect without ready flushes.
                    if (inst_ready_i || redirect_i) begin
                        valid_q <= 1'b0;
                        inst_q  <= NOP_INST;
                        pc_q    <= redirect_i ? redirect_target : pc_plus4;
                        state_q <= StReq;
                    end
                end
                default: state_q <= StReqIdle;
            endcase
        end
    end

endmodule
